// File: rtl/dep_issue_scheduler.sv
// dep_issue_scheduler
//   Dependency-matrix issue scheduler. Each instruction-buffer slot holds a
//   dependency row; a slot becomes ready once its row is all-zero, is offered
//   over a registered valid/ready issue port, and is freed when it completes.
//   Completion clears the completing slot's column in every row.
//
// Parameters
//   bs              number of buffer slots (power of two, >= 2)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   alloc_*         allocate slot alloc_index with dependency vector alloc_idt
//   complete_*      slot complete_index finished execution
//   issue_valid/index/ready   registered issue offer and accept handshake
//   occupancy, full, empty    count of allocated, not yet completed slots
//   err             one-cycle pulse: alloc to occupied slot, or completion
//                   of a slot that is not issued
//
// Build option
//   ROUND_ROBIN_ISSUE_EN  when defined, selection starts at a round-robin
//                         pointer instead of fixed lowest-index priority.
module dep_issue_scheduler #(
   parameter int unsigned bs = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_valid,
   input  logic [$clog2(bs)-1:0] alloc_index,
   input  logic [bs-1:0]         alloc_idt,
   input  logic                  complete_valid,
   input  logic [$clog2(bs)-1:0] complete_index,
   output logic                  issue_valid,
   output logic [$clog2(bs)-1:0] issue_index,
   input  logic                  issue_ready,
   output logic [$clog2(bs):0]   occupancy,
   output logic                  full,
   output logic                  empty,
   output logic                  err
);

   localparam int unsigned IW = $clog2(bs);

   logic [bs-1:0] valid_q, valid_d;
   logic [bs-1:0] issued_q, issued_d;
   logic [bs-1:0] row_q [bs];
   logic [bs-1:0] row_d [bs];
   logic          issue_valid_q, issue_valid_d;
   logic [IW-1:0] issue_index_q, issue_index_d;
   logic [IW:0]   occ_q, occ_d;
   logic          err_q, err_d;

   logic          hs, comp_ok, alloc_free, alloc_ok, load, found;
   logic [bs-1:0] ready, new_row;
   logic [IW-1:0] start, idx, sel;

`ifdef ROUND_ROBIN_ISSUE_EN
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

   always_comb begin
      hs         = issue_valid_q & issue_ready;
      comp_ok    = complete_valid & valid_q[complete_index] & issued_q[complete_index];
      // a slot completing this cycle is freed before the alloc is considered
      alloc_free = ~valid_q[alloc_index] | (comp_ok & (complete_index == alloc_index));
      alloc_ok   = alloc_valid & alloc_free;

      // the slot sitting in the output register (held or handshaking) is excluded
      for (int unsigned s = 0; s < bs; s++) begin
         ready[s] = valid_q[s] & ~issued_q[s] & (row_q[s] == '0);
      end
      if (issue_valid_q) ready[issue_index_q] = 1'b0;

`ifdef ROUND_ROBIN_ISSUE_EN
      // pointer advances on handshake; the reload in that same edge already
      // searches from the advanced position
      rr_ptr_d = hs ? issue_index_q + {{(IW-1){1'b0}}, 1'b1} : rr_ptr_q;
      start    = rr_ptr_d;
`else
      start    = '0;
`endif
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < bs; k++) begin
         idx = start + IW'(k);
         if (!found && ready[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end

      new_row = alloc_idt;
      new_row[alloc_index] = 1'b0;
      if (complete_valid) new_row[complete_index] = 1'b0;

      // applied in order: completion, alloc, handshake
      valid_d  = valid_q;
      issued_d = issued_q;
      row_d    = row_q;
      if (comp_ok) begin
         for (int unsigned r = 0; r < bs; r++) row_d[r][complete_index] = 1'b0;
         valid_d[complete_index]  = 1'b0;
         issued_d[complete_index] = 1'b0;
      end
      if (alloc_ok) begin
         row_d[alloc_index]    = new_row;
         valid_d[alloc_index]  = 1'b1;
         issued_d[alloc_index] = 1'b0;
      end
      if (hs) issued_d[issue_index_q] = 1'b1;

      occ_d = occ_q + {{IW{1'b0}}, alloc_ok} - {{IW{1'b0}}, comp_ok};
      err_d = (alloc_valid & ~alloc_free) | (complete_valid & ~comp_ok);

      load          = ~issue_valid_q | issue_ready;
      issue_valid_d = load ? found : issue_valid_q;
      issue_index_d = load ? sel   : issue_index_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q       <= '0;
         issued_q      <= '0;
         for (int unsigned r = 0; r < bs; r++) row_q[r] <= '0;
         issue_valid_q <= 1'b0;
         issue_index_q <= '0;
         occ_q         <= '0;
         err_q         <= 1'b0;
`ifdef ROUND_ROBIN_ISSUE_EN
         rr_ptr_q      <= '0;
`endif
      end else begin
         valid_q       <= valid_d;
         issued_q      <= issued_d;
         for (int unsigned r = 0; r < bs; r++) row_q[r] <= row_d[r];
         issue_valid_q <= issue_valid_d;
         issue_index_q <= issue_index_d;
         occ_q         <= occ_d;
         err_q         <= err_d;
`ifdef ROUND_ROBIN_ISSUE_EN
         rr_ptr_q      <= rr_ptr_d;
`endif
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_index = issue_index_q;
   assign occupancy   = occ_q;
   assign full        = (occ_q == (IW+1)'(bs));
   assign empty       = (occ_q == '0);
   assign err         = err_q;

endmodule
